// File: rtl/mem_pkg.sv
// Shared types and constants for the SoC memory request bus.
package mem_pkg;

    localparam int unsigned TAG_W  = 8;
    localparam int unsigned TRSC_W = 8;
    localparam int unsigned MESI_W = 8;
    localparam int unsigned ADDR_W = 64;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [TRSC_W-1:0] trsc_t;
    typedef logic [MESI_W-1:0] mesi_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Tag 0 on the bus means "no request"; issued tags run 1..255.
    localparam tag_t TAG_IDLE  = 8'd0;
    localparam tag_t TAG_FIRST = 8'd1;

    localparam mesi_t MESI_INVALID   = 8'h00;
    localparam mesi_t MESI_SHARED    = 8'h01;
    localparam mesi_t MESI_EXCLUSIVE = 8'h02;
    localparam mesi_t MESI_MODIFIED  = 8'h03;

    // Request side of the bus as driven by the initiator.
    typedef struct packed {
        logic  lock;
        tag_t  rqst;
        trsc_t trsc;
        addr_t addr;
    } bus_req_t;

    // Next tag in sequence, skipping the idle encoding on wrap.
    function automatic tag_t next_tag(input tag_t t);
        return (t == 8'hFF) ? TAG_FIRST : tag_t'(t + tag_t'(1));
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Memory request bus: initiator drives lock/rqst/trsc/addr, responder returns resp/mesi.
interface mem_initiator_if;
    import mem_pkg::*;

    logic  lock;
    tag_t  rqst;
    trsc_t trsc;
    addr_t addr;
    tag_t  resp;
    mesi_t mesi;

    modport master (
        output lock,
        output rqst,
        output trsc,
        output addr,
        input  resp,
        input  mesi
    );

    modport slave (
        input  lock,
        input  rqst,
        input  trsc,
        input  addr,
        output resp,
        output mesi
    );

endinterface

// File: rtl/mem_initiator.sv
// Initiator end of the memory request bus: one outstanding tagged request at a time,
// completes on a matching resp echo or aborts after TIMEOUT cycles.
module mem_initiator
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req_valid,
    output logic  req_ready,
    input  trsc_t req_trsc,
    input  addr_t req_addr,
    input  logic  req_lock,
    output logic  done_valid,
    output tag_t  done_tag,
    output mesi_t done_mesi,
    output logic  done_err,
    mem_initiator_if.master m_mem
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t     state_q, state_d;
    tag_t       tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       keep_lock_q, keep_lock_d;
    bus_req_t   bus_q, bus_d;
    logic       req_ready_q, req_ready_d;
    logic       done_valid_q, done_valid_d;
    tag_t       done_tag_q, done_tag_d;
    mesi_t      done_mesi_q, done_mesi_d;
    logic       done_err_q, done_err_d;

    logic accept;
    logic match;
    logic expire;

    // Handshake is held off in the completion cycle even though req_ready is already high.
    assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q && !done_valid_q;
    // Issued tags are never zero, so resp==0 and stale echoes cannot match.
    assign match  = (state_q == ST_WAIT) && (m_mem.resp == tag_q);
    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and registered-output storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            tag_q        <= TAG_FIRST;
            cnt_q        <= '0;
            keep_lock_q  <= 1'b0;
            bus_q        <= '0;
            req_ready_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_tag_q   <= TAG_IDLE;
            done_mesi_q  <= MESI_INVALID;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            keep_lock_q  <= keep_lock_d;
            bus_q        <= bus_d;
            req_ready_q  <= req_ready_d;
            done_valid_q <= done_valid_d;
            done_tag_q   <= done_tag_d;
            done_mesi_q  <= done_mesi_d;
            done_err_q   <= done_err_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)           state_d = ST_WAIT;
            ST_WAIT: if (match || expire)  state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        keep_lock_d  = keep_lock_q;
        bus_d        = bus_q;
        req_ready_d  = req_ready_q;
        done_valid_d = 1'b0;
        done_tag_d   = done_tag_q;
        done_mesi_d  = done_mesi_q;
        done_err_d   = done_err_q;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    bus_d.rqst  = tag_q;
                    bus_d.trsc  = req_trsc;
                    bus_d.addr  = req_addr;
                    bus_d.lock  = 1'b1;
                    keep_lock_d = req_lock;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (match) begin
                    // Match takes priority over a timeout expiring in the same cycle.
                    done_valid_d = 1'b1;
                    done_tag_d   = tag_q;
                    done_mesi_d  = m_mem.mesi;
                    done_err_d   = 1'b0;
                    bus_d.rqst   = TAG_IDLE;
                    bus_d.lock   = keep_lock_q;
                    req_ready_d  = 1'b1;
                    tag_d        = next_tag(tag_q);
                end else if (expire) begin
                    done_valid_d = 1'b1;
                    done_tag_d   = tag_q;
                    done_mesi_d  = MESI_INVALID;
                    done_err_d   = 1'b1;
                    bus_d.rqst   = TAG_IDLE;
                    bus_d.lock   = 1'b0;
                    req_ready_d  = 1'b1;
                    tag_d        = next_tag(tag_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign done_valid = done_valid_q;
    assign done_tag   = done_tag_q;
    assign done_mesi  = done_mesi_q;
    assign done_err   = done_err_q;
    assign m_mem.lock = bus_q.lock;
    assign m_mem.rqst = bus_q.rqst;
    assign m_mem.trsc = bus_q.trsc;
    assign m_mem.addr = bus_q.addr;

endmodule
